// File: rtl/rand_pkg.sv
// Shared types and helpers for the entropy whitening path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rand_pkg;

  // Pair extraction control states.
  typedef enum logic {
    IDLE    = 1'b0,
    EXTRACT = 1'b1
  } state_t;

  // Von Neumann pair codes {d[2k+1], d[2k]} that produce an output bit.
  localparam logic [1:0] PAIR_ONE  = 2'b10;
  localparam logic [1:0] PAIR_ZERO = 2'b01;

  // Ceiling log2, used for pointer and counter widths (minimum 1 bit).
  function automatic int clog2(input int value);
    int width;
    width = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/rand_fifo.sv
// Generic first-word-fall-through FIFO: head word always visible on oData while not empty.
// Latency: a push into an empty FIFO is visible on the next cycle.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
module rand_fifo
  import rand_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iPush,
  input  logic [WIDTH-1:0] iPushData,
  input  logic             iPop,
  output logic [WIDTH-1:0] oData,
  output logic             oFull,
  output logic             oEmpty
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic [AW:0]      count;
  logic             doPush;
  logic             doPop;

  assign oFull  = (count == (AW + 1)'(DEPTH));
  assign oEmpty = (count == '0);
  assign oData  = mem[rdPtr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPop  = iPop & ~oEmpty;
  assign doPush = iPush & (~oFull | doPop);

  // Storage, pointers and occupancy; reset clears the array so oData reads 0.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= iPushData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rand_vn_whiten.sv
// Von Neumann debiaser: one raw pair per cycle, surviving bits packed LSB-first into FIFO words.
// Latency: iValid at cycle t, word completing on pair k -> oValid at t+k+2; busy ws/2 cycles per word.
// Backpressure: raw words arriving while busy and packed words hitting a full FIFO are dropped (sticky oOvf).
// Optional build macro RAND_HEALTH_EN adds a repetition-count health test driving oFail.
module rand_vn_whiten
  import rand_pkg::*;
#(
  parameter int ws        = 16,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 4
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic [ws-1:0] iData,
  input  logic          iValid,
  input  logic          iReady,
  output logic [ws-1:0] oData,
  output logic          oValid,
  output logic          oBusy,
  output logic          oOvf,
  output logic          oFail
);

  localparam int PW = clog2(ws / 2);
  localparam int CW = clog2(ws);

  state_t          state;
  state_t          nextState;
  logic [ws-1:0]   shiftReg;
  logic [PW-1:0]   pairCnt;
  logic [ws-1:0]   pack;
  logic [ws-1:0]   packNext;
  logic [CW-1:0]   packCnt;
  logic [1:0]      pair;
  logic            accept;
  logic            lastPair;
  logic            emitVld;
  logic            emitBit;
  logic            pushReq;
  logic            fifoFull;
  logic            fifoEmpty;
  logic            ovf;
  logic            failed;

  assign accept   = (state == IDLE) & iValid & ~failed;
  assign lastPair = (pairCnt == PW'(ws / 2 - 1));
  assign pair     = shiftReg[1:0];
  assign oBusy    = (state == EXTRACT);
  assign oValid   = ~fifoEmpty;
  assign oOvf     = ovf;
  assign oFail    = failed;

  // State register.
  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= nextState;
  end

  // Next state: leave IDLE on an accepted word, return after the last pair.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = EXTRACT;
      EXTRACT: if (lastPair) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Pair decode and packing; the completed word is pushed in the cycle its last bit lands.
  always_comb begin
    emitVld  = (state == EXTRACT) & ~failed & ((pair == PAIR_ONE) | (pair == PAIR_ZERO));
    emitBit  = (pair == PAIR_ONE);
    packNext = pack;
    if (emitVld) packNext[packCnt] = emitBit;
    pushReq  = emitVld & (packCnt == CW'(ws - 1));
  end

  // Raw-word shift register and pair counter.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      shiftReg <= '0;
      pairCnt  <= '0;
    end else if (accept) begin
      shiftReg <= iData;
      pairCnt  <= '0;
    end else if (state == EXTRACT) begin
      shiftReg <= {2'b00, shiftReg[ws-1:2]};
      pairCnt  <= pairCnt + PW'(1);
    end
  end

  // Pack register and bit count; partial words carry over between raw words.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pack    <= '0;
      packCnt <= '0;
    end else if (emitVld) begin
      pack    <= packNext;
      packCnt <= pushReq ? '0 : packCnt + CW'(1);
    end
  end

  // Sticky overflow: raw word during extraction, or packed word into a full FIFO with no pop.
  always_ff @(posedge iCLK) begin
    if (iRST) ovf <= 1'b0;
    else if ((iValid && state == EXTRACT) || (pushReq && fifoFull && !iReady)) ovf <= 1'b1;
  end

`ifdef RAND_HEALTH_EN
  localparam int RW = clog2(REP_LIMIT + 1);

  logic [ws-1:0] lastWord;
  logic [RW-1:0] repCnt;
  logic [RW-1:0] repNext;
  logic          failReg;

  // Run length including the word being accepted; zero count means no previous word yet.
  always_comb begin
    repNext = RW'(1);
    if (repCnt != '0 && iData == lastWord) repNext = repCnt + RW'(1);
  end

  // Repetition tracker; once tripped, accept is blocked so the count freezes.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      lastWord <= '0;
      repCnt   <= '0;
      failReg  <= 1'b0;
    end else if (accept) begin
      lastWord <= iData;
      repCnt   <= repNext;
      if (repNext == RW'(REP_LIMIT)) failReg <= 1'b1;
    end
  end

  assign failed = failReg;
`else
  logic unusedRepLimit;
  assign unusedRepLimit = ^REP_LIMIT;
  assign failed         = 1'b0;
`endif

  rand_fifo #(
    .WIDTH (ws),
    .DEPTH (DEPTH)
  ) uFifo (
    .iCLK      (iCLK),
    .iRST      (iRST),
    .iPush     (pushReq),
    .iPushData (packNext),
    .iPop      (iReady),
    .oData     (oData),
    .oFull     (fifoFull),
    .oEmpty    (fifoEmpty)
  );

endmodule

// File: tb/tb_rand_vn_whiten.sv
// Directed bench for rand_vn_whiten: table of multi-word vectors plus hand sequences.
// Latency: checks t+k+2 output timing and ws/2-cycle busy window.
// Backpressure: exercises full-FIFO drop, simultaneous push/pop and overlapping strobes.
module tb_rand_vn_whiten;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [15:0] iData;
  logic        iValid;
  logic        iReady;
  logic [15:0] oData;
  logic        oValid;
  logic        oBusy;
  logic        oOvf;
  logic        oFail;

  int total = 0;
  int bad   = 0;

  always #5 iCLK = ~iCLK;

  rand_vn_whiten #(.ws(16), .DEPTH(4), .REP_LIMIT(4)) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iData  (iData),
    .iValid (iValid),
    .iReady (iReady),
    .oData  (oData),
    .oValid (oValid),
    .oBusy  (oBusy),
    .oOvf   (oOvf),
    .oFail  (oFail)
  );

  typedef struct {
    logic [3:0][15:0] w;
    int               n;
    int               kDone;
    logic [15:0]      exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic doReset();
    iRST   = 1'b1;
    iValid = 1'b0;
    iReady = 1'b0;
    idle(2);
    iRST = 1'b0;
  endtask

  task automatic feed(input logic [15:0] w);
    iData  = w;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
  endtask

  // Pops everything available, checking each word and the final count.
  task automatic drain(input string name, input logic [15:0] expData, input int expCount);
    int got;
    got    = 0;
    iReady = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (oValid) begin
        check({name, " data"}, oData, expData);
        got++;
      end
      tick();
    end
    iReady = 1'b0;
    check({name, " count"}, got, expCount);
  endtask

  initial begin
    int busy;
    int lat;

    vecs[0] = '{w: {16'h0, 16'h0, 16'hAAAA, 16'hAAAA}, n: 2, kDone: 7, exp: 16'hFFFF};
    vecs[1] = '{w: {16'h0, 16'h0, 16'h5555, 16'hAAAA}, n: 2, kDone: 7, exp: 16'h00FF};
    vecs[2] = '{w: {16'h0, 16'h0, 16'hAAAA, 16'h5555}, n: 2, kDone: 7, exp: 16'hFF00};
    vecs[3] = '{w: {16'h0, 16'h0, 16'hAAAA, 16'h9999}, n: 2, kDone: 7, exp: 16'hFFAA};
    vecs[4] = '{w: {16'h0, 16'h0, 16'h6666, 16'h6666}, n: 2, kDone: 7, exp: 16'h5555};
    vecs[5] = '{w: {16'h0, 16'h5555, 16'hAAAA, 16'hF0AA}, n: 3, kDone: 3, exp: 16'h0FFF};
    vecs[6] = '{w: {16'h0, 16'h5555, 16'h5555, 16'h00FF}, n: 3, kDone: 7, exp: 16'h0000};
    vecs[7] = '{w: {16'h5555, 16'hFFFF, 16'h0000, 16'hAAAA}, n: 4, kDone: 7, exp: 16'h00FF};

    // Reset held 3 cycles with iValid toggling.
    iRST   = 1'b1;
    iReady = 1'b1;
    iData  = 16'hAAAA;
    for (int i = 0; i < 3; i++) begin
      iValid = (i % 2 == 0);
      tick();
    end
    iRST   = 1'b0;
    iValid = 1'b0;
    iReady = 1'b0;
    check("rst oData", oData, 0);
    check("rst oValid", oValid, 0);
    check("rst oBusy", oBusy, 0);
    check("rst oOvf", oOvf, 0);
    check("rst oFail", oFail, 0);
    feed(16'hAAAA);
    check("post-rst accept", oBusy, 1);
    idle(12);
    feed(16'hAAAA);
    idle(12);
    drain("post-rst word", 16'hFFFF, 1);

    // Table vectors, each from a clean reset with output held back.
    for (int v = 0; v < 8; v++) begin
      doReset();
      for (int i = 0; i < vecs[v].n; i++) begin
        feed(vecs[v].w[i]);
        if (i == 0) begin
          busy = 0;
          for (int j = 0; j < 12; j++) begin
            if (oBusy) busy++;
            tick();
          end
          check($sformatf("vec%0d busy", v), busy, 8);
        end
        if (i < vecs[v].n - 1) begin
          if (i != 0) idle(12);
          check($sformatf("vec%0d early", v), oValid, 0);
        end else begin
          lat = 1;
          while (!oValid && lat < 40) begin
            tick();
            lat++;
          end
          check($sformatf("vec%0d latency", v), lat, vecs[v].kDone + 2);
          check($sformatf("vec%0d data", v), oData, vecs[v].exp);
          iReady = 1'b1;
          tick();
          iReady = 1'b0;
          check($sformatf("vec%0d single", v), oValid, 0);
          check($sformatf("vec%0d ovf", v), oOvf, 0);
        end
      end
    end

    // Reset in mid-extraction discards FIFO, partial word and overflow flag.
    doReset();
    feed(16'hAAAA);
    idle(12);
    feed(16'hAAAA);
    idle(12);
    feed(16'hAAAA);
    feed(16'h5555);
    idle(2);
    check("pre-rst ovf", oOvf, 1);
    check("pre-rst valid", oValid, 1);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    check("midrst valid", oValid, 0);
    check("midrst busy", oBusy, 0);
    check("midrst ovf", oOvf, 0);
    check("midrst data", oData, 0);
    feed(16'hAAAA);
    idle(12);
    feed(16'h5555);
    idle(12);
    drain("midrst word", 16'h00FF, 1);

    // Strobes on two consecutive cycles: the second is dropped.
    doReset();
    iData  = 16'hAAAA;
    iValid = 1'b1;
    tick();
    iData = 16'h5555;
    tick();
    iValid = 1'b0;
    idle(12);
    check("overlap ovf", oOvf, 1);
    feed(16'hAAAA);
    idle(12);
    drain("overlap word", 16'hFFFF, 1);

    // Strobe in the final-pair cycle is dropped; the next cycle is idle again.
    doReset();
    feed(16'hAAAA);
    idle(7);
    check("lastpair busy", oBusy, 1);
    feed(16'h5555);
    check("after lastpair busy", oBusy, 0);
    check("lastpair ovf", oOvf, 1);
    feed(16'hAAAA);
    idle(12);
    drain("lastpair word", 16'hFFFF, 1);

    // Full FIFO: push and pop in the same cycle both succeed.
    doReset();
    for (int i = 0; i < 8; i++) begin
      feed(16'hAAAA);
      idle(10);
    end
    check("full ovf", oOvf, 0);
    feed(16'hAAAA);
    idle(10);
    feed(16'hAAAA);
    idle(7);
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    check("pushpop ovf", oOvf, 0);
    drain("pushpop", 16'hFFFF, 4);

    // Backpressure: ten words make five packed words, fifth dropped.
    doReset();
    for (int i = 0; i < 10; i++) begin
      feed(16'hAAAA);
      idle(10);
      if (i == 7) check("bp ovf before", oOvf, 0);
    end
    check("bp ovf after", oOvf, 1);
    drain("bp drain", 16'hFFFF, 4);
    check("bp ovf sticky", oOvf, 1);

    // Repetition health test.
    doReset();
    for (int i = 0; i < 4; i++) begin
      feed(16'h1234);
      if (i == 2) check("health before", oFail, 0);
      if (i == 3) begin
`ifdef RAND_HEALTH_EN
        check("health trip", oFail, 1);
`else
        check("health off", oFail, 0);
`endif
      end
      idle(10);
    end
`ifdef RAND_HEALTH_EN
    feed(16'hAAAA);
    check("health reject", oBusy, 0);
    idle(10);
    feed(16'hAAAA);
    idle(12);
    check("health no output", oValid, 0);
    check("health sticky", oFail, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rand_vn_whiten.md
Name: rand_vn_whiten

Overview:
- Downstream consumer of the raw entropy samplers (the ADC- and clock-jitter-based word collectors).
- Takes one ws-bit raw word per strobe and applies von Neumann debiasing, one bit pair per clock.
- Packs the surviving bits LSB-first into ws-bit output words.
- Buffers packed words in a small FIFO behind a valid/ready handshake for the application logic.

Parameters:
- ws, 16, raw and output word width; must be even and at least 4.
- DEPTH, 4, FIFO depth in words; power of 2, at least 2.
- REP_LIMIT, 4, consecutive identical raw words that trip the health test (used only with RAND_HEALTH_EN).

Ports:
- iCLK  input  1  single clock; all state updates on posedge.
- iRST  input  1  synchronous reset, active-high.
- iData  input  ws  raw word from the sampler.
- iValid  input  1  one-cycle strobe marking a new iData.
- iReady  input  1  consumer ready.
- oData  output  ws  packed whitened word (FIFO head).
- oValid  output  1  oData valid.
- oBusy  output  1  pair extraction in progress.
- oOvf  output  1  sticky: an input word or packed word was dropped.
- oFail  output  1  sticky health-test failure (0 without RAND_HEALTH_EN).

Behaviour:
- Reset (iRST=1 at posedge):
  - oData=0, oValid=0, oBusy=0, oOvf=0, oFail=0.
  - FIFO emptied, pack count=0, pack register=0, state=IDLE.
  - Reset mid-extraction discards the partial word and all FIFO contents.
- States: IDLE, EXTRACT.
  - IDLE: iValid=1 loads iData into the shift register, clears the pair counter, and moves to EXTRACT. oBusy=1 from the next cycle.
  - EXTRACT: processes pair k={d[2k+1],d[2k]}, k=0..ws/2-1, one pair per cycle. After pair ws/2-1, returns to IDLE; oBusy=0 the following cycle.
  - Total busy time is exactly ws/2 cycles per accepted word.
- Pair rule:
  - 2'b10 emits bit 1.
  - 2'b01 emits bit 0.
  - 2'b00 and 2'b11 emit nothing.
- Packing:
  - Each emitted bit is written into pack[cnt], then cnt increments.
  - When cnt reaches ws-1 and a bit is emitted, the full word is pushed to the FIFO in that same cycle and cnt wraps to 0.
  - Partial words carry over across input words.
- iValid while oBusy=1, including the final-pair cycle: the word is dropped and oOvf is set. This is the intended backstop, since the sampler rate is at most 1 word per 16 slow clocks.
- FIFO:
  - Registered, first-word-fall-through. oValid=1 the cycle after a push into an empty FIFO.
  - A pop occurs when oValid & iReady.
  - Push into a full FIFO drops the packed word and sets oOvf. A push and a pop in the same cycle while full both succeed.
- Latency: with iValid at cycle t and a word completing on pair k, oValid is high at cycle t+k+2.
- oOvf and oFail clear only on reset.

Optional Feature:
- Macro: RAND_HEALTH_EN.
- When defined, a repetition-count test runs on accepted raw words:
  - A counter tracks consecutive equal words.
  - When it reaches REP_LIMIT, oFail is set.
  - From then on all input words are discarded and nothing new is pushed; FIFO contents still drain.
- When undefined: no comparator or counter logic, oFail tied 0, REP_LIMIT unused.

Decomposition:
- Package rand_pkg holds:
  - state enum {IDLE, EXTRACT}
  - pair codes PAIR_ONE=2'b10, PAIR_ZERO=2'b01
  - the DEPTH pointer-width function clog2
- Sub-module rand_fifo (ws-wide, DEPTH-deep FWFT FIFO with push/pop/full/empty) is natural and reusable by the sampler blocks.

Test Plan:
1. Reset: hold iRST 3 cycles with iValid toggling -> all outputs 0, FIFO empty; first word after release accepted normally.
2. Ones: feed 16'hAAAA twice, 20 cycles apart, iReady=1 -> one word oData=16'hFFFF, oValid 1 cycle; oBusy high exactly 8 cycles per word.
3. Mixed: 16'hAAAA then 16'h5555 -> oData=16'h00FF. Then 16'h0000 and 16'hFFFF -> no output, cnt unchanged.
4. Backpressure: iReady=0, DEPTH=4, ten 16'hAAAA words -> 4 stored, 5th packed word dropped, oOvf=1; raising iReady then drains exactly 4x16'hFFFF.
5. Overlap: iValid on two consecutive cycles -> second word dropped, oOvf=1, output reflects the first word only.
6. Health (RAND_HEALTH_EN, REP_LIMIT=4): four 16'h1234 words -> oFail=1 after the 4th accept; a following 16'hAAAA produces no output. Rebuilt without the macro, oFail stays 0.
